vga_scan_engine: RTL and testbench

- Parametrised successor to the fixed 640x480 scan logic; runs entirely in the pixel clock domain.
- Generates programmable H/V timing and issues framebuffer read requests with integer pixel replication (SCALE).
- Captures the returned pixel data and drives latency-aligned VGA colour, sync and blank outputs.
- Supports configurable sync polarity, channel width, mono/RGB mode, an enable gate, and frame/line markers for the draw side.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_delay_line.sv | 28 ++
 rtl/vga_scan_engine.sv | 185 ++++++++++++++++++
 tb/tb_vga_scan_engine.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing types, the stock 640x480@60 timing set and elaboration-time
// configuration helpers for the VGA scan engine.
package vga_pkg;

    typedef struct packed {
        int unsigned h_vis;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_vis;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_vis: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_vis: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

    // Ceiling log2, never below 1 so derived vectors always have a bit.
    function automatic int unsigned vga_clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) w++;
        return w;
    endfunction

    function automatic bit vga_cfg_ok(input int unsigned h_vis, input int unsigned v_vis,
                                      input int unsigned scale, input int unsigned rd_lat);
        return (scale == 1 || scale == 2 || scale == 4) &&
               (h_vis % scale == 0) && (v_vis % scale == 0) && (rd_lat >= 1);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous clear; aligns the stage-0
// decode bundle with the framebuffer return path.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            stage <= '{default: '0};
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_engine.sv
// Programmable VGA raster generator: H/V counters, replicated framebuffer
// addressing and latency-aligned colour/sync/blank/marker outputs.
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS  = VGA_640x480_60.h_vis,
    parameter int unsigned H_FP   = VGA_640x480_60.h_fp,
    parameter int unsigned H_SYNC = VGA_640x480_60.h_sync,
    parameter int unsigned H_BP   = VGA_640x480_60.h_bp,
    parameter int unsigned V_VIS  = VGA_640x480_60.v_vis,
    parameter int unsigned V_FP   = VGA_640x480_60.v_fp,
    parameter int unsigned V_SYNC = VGA_640x480_60.v_sync,
    parameter int unsigned V_BP   = VGA_640x480_60.v_bp,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b0,
    parameter int unsigned SCALE  = 2,
    parameter int unsigned CH_W   = 8,
    parameter bit          MONO   = 1'b1,
    parameter int unsigned RD_LAT = 1,
    localparam int unsigned ADDR_W = vga_clog2((H_VIS/SCALE)*(V_VIS/SCALE)),
    localparam int unsigned PIX_W  = MONO ? CH_W : 3*CH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  pix_in,
    output logic [CH_W-1:0]   VGA_R,
    output logic [CH_W-1:0]   VGA_G,
    output logic [CH_W-1:0]   VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              VGA_SYNC_N,
    output logic              frame_start,
    output logic              line_start
);

    if (!vga_cfg_ok(H_VIS, V_VIS, SCALE, RD_LAT)) begin : g_bad_cfg
        $error("vga_scan_engine: SCALE must be 1/2/4 dividing H_VIS and V_VIS, RD_LAT >= 1");
    end

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW    = vga_clog2(H_TOT);
    localparam int unsigned VW    = vga_clog2(V_TOT);
    localparam int unsigned SW    = vga_clog2(SCALE);

    localparam logic [HW-1:0]     H_VIS_C   = HW'(H_VIS);
    localparam logic [HW-1:0]     H_HS_BEG  = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0]     H_HS_LAST = HW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0]     H_LAST    = HW'(H_TOT - 1);
    localparam logic [VW-1:0]     V_VIS_C   = VW'(V_VIS);
    localparam logic [VW-1:0]     V_VS_BEG  = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0]     V_VS_LAST = VW'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0]     V_LAST    = VW'(V_TOT - 1);
    localparam logic [SW-1:0]     S_LAST    = SW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(H_VIS / SCALE);

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [SW-1:0]     sx, sy;
    logic [ADDR_W-1:0] col, row_base;

    logic h_end, v_end, v_vis, act, hs_a, vs_a, fs_a, ls_a;

    always_comb begin
        h_end = (h_cnt == H_LAST);
        v_end = (v_cnt == V_LAST);
        v_vis = (v_cnt < V_VIS_C);
        act   = en && (h_cnt < H_VIS_C) && v_vis;
        hs_a  = en && (h_cnt >= H_HS_BEG) && (h_cnt <= H_HS_LAST);
        vs_a  = en && (v_cnt >= V_VS_BEG) && (v_cnt <= V_VS_LAST);
        fs_a  = act && (h_cnt == '0) && (v_cnt == '0);
        ls_a  = act && (h_cnt == '0);
    end

    // row_base/col track the counter position so rd_addr = row_base + col
    // without a multiplier; sx/sy count replications of a source pixel/line.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            sx       <= '0;
            sy       <= '0;
            col      <= '0;
            row_base <= '0;
        end else if (en) begin
            if (h_end) begin
                h_cnt <= '0;
                col   <= '0;
                sx    <= '0;
                if (v_end) begin
                    v_cnt    <= '0;
                    sy       <= '0;
                    row_base <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                    if (v_vis) begin
                        if (sy == S_LAST) begin
                            sy       <= '0;
                            row_base <= row_base + ROW_STEP;
                        end else begin
                            sy <= sy + 1'b1;
                        end
                    end
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
                if (act) begin
                    if (sx == S_LAST) begin
                        sx  <= '0;
                        col <= col + 1'b1;
                    end else begin
                        sx <= sx + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            rd_en <= act;
            if (act) rd_addr <= row_base + col;
        end
    end

    // Depth RD_LAT+1 lines the decode up with pix_in; the output register adds the last cycle.
    logic [4:0] dly_q;
    logic       d_act, d_hs, d_vs, d_fs, d_ls;

    vga_delay_line #(
        .WIDTH (5),
        .DEPTH (RD_LAT + 1)
    ) u_dly (
        .clk (clk),
        .clr (rst),
        .d   ({act, hs_a, vs_a, fs_a, ls_a}),
        .q   (dly_q)
    );

    assign {d_act, d_hs, d_vs, d_fs, d_ls} = dly_q;

    logic [CH_W-1:0] pix_r, pix_g, pix_b;

    if (MONO) begin : g_mono
        assign pix_r = pix_in;
        assign pix_g = pix_in;
        assign pix_b = pix_in;
    end else begin : g_rgb
        assign pix_r = pix_in[3*CH_W-1 -: CH_W];
        assign pix_g = pix_in[2*CH_W-1 -: CH_W];
        assign pix_b = pix_in[CH_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            VGA_BLANK_N <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            VGA_R       <= d_act ? pix_r : '0;
            VGA_G       <= d_act ? pix_g : '0;
            VGA_B       <= d_act ? pix_b : '0;
            VGA_HS      <= d_hs ? HS_POL : ~HS_POL;
            VGA_VS      <= d_vs ? VS_POL : ~VS_POL;
            VGA_BLANK_N <= d_act;
            frame_start <= d_fs;
            line_start  <= d_ls;
        end
    end

    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench on a reduced 14x7 raster: three engine variants share one
// stimulus stream; expected outputs come from closed-form pixel arithmetic.
module tb_vga_scan_engine;

    logic clk, rst, en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: SCALE 1, RD_LAT 1, mono, active-low syncs
    logic       a_rd_en, a_hs, a_vs, a_blank_n, a_sync_n, a_fs, a_ls;
    logic [4:0] a_addr;
    logic [7:0] a_pix, a_r, a_g, a_b;
    // B: SCALE 2, RD_LAT 1, mono, active-high syncs
    logic       b_rd_en, b_hs, b_vs, b_blank_n, b_sync_n, b_fs, b_ls;
    logic [2:0] b_addr;
    logic [7:0] b_pix, b_r, b_g, b_b;
    // C: SCALE 1, RD_LAT 3, RGB, active-low syncs
    logic        c_rd_en, c_hs, c_vs, c_blank_n, c_sync_n, c_fs, c_ls;
    logic [4:0]  c_addr;
    logic [23:0] c_pix;
    logic [7:0]  c_r, c_g, c_b;
    logic [23:0] c_pipe [3];

    vga_scan_engine #(
        .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE(1), .CH_W(8), .MONO(1'b1), .RD_LAT(1)
    ) u_a (
        .clk(clk), .rst(rst), .en(en), .rd_en(a_rd_en), .rd_addr(a_addr), .pix_in(a_pix),
        .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .VGA_HS(a_hs), .VGA_VS(a_vs),
        .VGA_BLANK_N(a_blank_n), .VGA_SYNC_N(a_sync_n), .frame_start(a_fs), .line_start(a_ls)
    );

    vga_scan_engine #(
        .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .SCALE(2), .CH_W(8), .MONO(1'b1), .RD_LAT(1)
    ) u_b (
        .clk(clk), .rst(rst), .en(en), .rd_en(b_rd_en), .rd_addr(b_addr), .pix_in(b_pix),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_HS(b_hs), .VGA_VS(b_vs),
        .VGA_BLANK_N(b_blank_n), .VGA_SYNC_N(b_sync_n), .frame_start(b_fs), .line_start(b_ls)
    );

    vga_scan_engine #(
        .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE(1), .CH_W(8), .MONO(1'b0), .RD_LAT(3)
    ) u_c (
        .clk(clk), .rst(rst), .en(en), .rd_en(c_rd_en), .rd_addr(c_addr), .pix_in(c_pix),
        .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b), .VGA_HS(c_hs), .VGA_VS(c_vs),
        .VGA_BLANK_N(c_blank_n), .VGA_SYNC_N(c_sync_n), .frame_start(c_fs), .line_start(c_ls)
    );

    // Framebuffer stand-ins: the word at address N holds N (C: {N, ~N, 5A}).
    always @(posedge clk) begin
        a_pix     <= {3'b000, a_addr};
        b_pix     <= {5'b00000, b_addr};
        c_pipe[0] <= {3'b000, a_addr == a_addr ? c_addr : c_addr, ~{3'b000, c_addr}, 8'h5A};
        c_pipe[1] <= c_pipe[0];
        c_pipe[2] <= c_pipe[1];
    end
    assign c_pix = c_pipe[2];

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int px_h(input int n);
        return n % 14;
    endfunction
    function automatic int px_v(input int n);
        return (n / 14) % 7;
    endfunction
    function automatic bit px_vis(input int n);
        return px_h(n) < 8 && px_v(n) < 4;
    endfunction
    function automatic int px_addr(input int n, input int sc);
        return (px_v(n) / sc) * (8 / sc) + px_h(n) / sc;
    endfunction

    // hv/hn[k]: scan position (and whether it was live) consumed k+1 edges ago.
    bit hv [8];
    int hn [8];
    int n_cur = 0, cyc = 0, last_rst = 0, last_fs = 0;
    int ea_a = 0, ea_b = 0, ea_c = 0;
    bit fs_pending = 1'b0;
    int periods [$];

    task automatic check_out(input string id, input int lat, input int sc, input bit pol,
                             input bit mono, input logic blank_n, input logic hs, input logic vs,
                             input logic fs, input logic ls, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b, input logic ren,
                             input logic [31:0] raddr, input int ea);
        bit v, vis;
        int n, h, vv, ad;
        string at;
        v   = hv[lat-1];
        n   = hn[lat-1];
        h   = px_h(n);
        vv  = px_v(n);
        vis = v && px_vis(n);
        ad  = vis ? px_addr(n, sc) : 0;
        at  = $sformatf("@%0d", cyc);
        check_eq({id, " blank_n", at}, 32'(blank_n), 32'(vis));
        check_eq({id, " hs", at}, 32'(hs), 32'((v && h >= 10 && h <= 11) ? pol : !pol));
        check_eq({id, " vs", at}, 32'(vs), 32'((v && vv == 5) ? pol : !pol));
        check_eq({id, " frame_start", at}, 32'(fs), 32'(vis && h == 0 && vv == 0));
        check_eq({id, " line_start", at}, 32'(ls), 32'(vis && h == 0));
        check_eq({id, " r", at}, 32'(r), 32'(ad));
        check_eq({id, " g", at}, 32'(g), 32'(vis ? (mono ? ad : 255 - ad) : 0));
        check_eq({id, " b", at}, 32'(b), 32'(vis ? (mono ? ad : 32'h5A) : 0));
        check_eq({id, " rd_en", at}, 32'(ren), 32'(hv[0] && px_vis(hn[0])));
        check_eq({id, " rd_addr", at}, raddr, 32'(ea));
    endtask

    task automatic step();
        bit s_valid;
        int s_n;
        s_valid = en;
        s_n     = n_cur;
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                hv[i] = 1'b0;
                hn[i] = 0;
            end
            n_cur      = 0;
            ea_a       = 0;
            ea_b       = 0;
            ea_c       = 0;
            last_rst   = cyc;
            fs_pending = 1'b1;
        end else begin
            for (int i = 7; i > 0; i--) begin
                hv[i] = hv[i-1];
                hn[i] = hn[i-1];
            end
            hv[0] = s_valid;
            hn[0] = s_n;
            if (s_valid && px_vis(s_n)) begin
                ea_a = px_addr(s_n, 1);
                ea_b = px_addr(s_n, 2);
                ea_c = px_addr(s_n, 1);
            end
            if (en) n_cur++;
        end
        @(negedge clk);
        check_out("A", 3, 1, 1'b0, 1'b1, a_blank_n, a_hs, a_vs, a_fs, a_ls, a_r, a_g, a_b,
                  a_rd_en, 32'(a_addr), ea_a);
        check_out("B", 3, 2, 1'b1, 1'b1, b_blank_n, b_hs, b_vs, b_fs, b_ls, b_r, b_g, b_b,
                  b_rd_en, 32'(b_addr), ea_b);
        check_out("C", 5, 1, 1'b0, 1'b0, c_blank_n, c_hs, c_vs, c_fs, c_ls, c_r, c_g, c_b,
                  c_rd_en, 32'(c_addr), ea_c);
        check_eq($sformatf("A sync_n @%0d", cyc), 32'(a_sync_n), 32'd0);
        if (a_fs) begin
            if (fs_pending) check_eq("A frame_start after reset", cyc - last_rst, 3);
            else periods.push_back(cyc - last_fs);
            last_fs    = cyc;
            fs_pending = 1'b0;
        end
    endtask

    task automatic run_to(input int target, input int budget);
        int k;
        k = 0;
        while (n_cur != target && k < budget) begin
            step();
            k++;
        end
        check_eq("scan position reached", n_cur, target);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        step();
        step();
        rst = 1'b0;
        // Full first frame, wrap, then freeze at (4,1) of frame 2.
        run_to(116, 200);
        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
        step();
        check_eq("A resume rd_en", 32'(a_rd_en), 32'd1);
        check_eq("A resume rd_addr", 32'(a_addr), 32'd12);
        // Reset mid-frame at (6,2) of frame 3.
        run_to(230, 200);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (110) step();
        check_eq("frame period count", periods.size(), 3);
        check_eq("frame period", periods.size() > 0 ? periods[0] : -1, 98);
        check_eq("frame period with pause", periods.size() > 1 ? periods[1] : -1, 103);
        check_eq("frame period after reset", periods.size() > 2 ? periods[2] : -1, 98);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
